// File: rtl/ecliptic_converter_sequencer.sv
// Sequences one float<->word conversion at a time: accepts a command, resolves the
// rounding mode, drives the selected converter, waits (bounded) for its ack and returns the result.
module ecliptic_converter_sequencer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_op,
    input  logic        in_unsigned,
    input  logic [2:0]  in_rm,
    input  logic [31:0] in_src,
    input  logic [4:0]  in_tag,
    input  logic [2:0]  frm,
    output logic        w_req,
    output logic [31:0] w_src,
    output logic [1:0]  w_rm,
    output logic        w_unsigned,
    input  logic        w_ack,
    input  logic [31:0] w_res,
    input  logic        w_invalid,
    input  logic        w_inexact,
    output logic        f_req,
    output logic [31:0] f_src,
    output logic [1:0]  f_rm,
    output logic        f_unsigned,
    input  logic        f_ack,
    input  logic [31:0] f_res,
    input  logic        f_inexact,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res,
    output logic [4:0]  out_tag,
    output logic [1:0]  out_status,
    output logic [4:0]  fflags,
    input  logic        fflags_clr
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [1:0] ST_OK = 2'd0, ST_ILLEGAL_RM = 2'd1, ST_TIMEOUT = 2'd2;

    state_t      state, state_nxt;
    logic        op_q, uns_q;
    logic [31:0] src_q, res_q;
    logic [4:0]  tag_q, fflags_nxt;
    logic [1:0]  rm_q, status_q;
    logic [7:0]  cnt_q;
    logic [2:0]  rm_res;
    logic        sel_ack, expired, drive;

    // DYN defers to frm; any resolved mode >= 4 is rejected without touching a converter.
    assign rm_res  = (in_rm == 3'd7) ? frm : in_rm;
    assign sel_ack = op_q ? f_ack : w_ack;
    assign expired = (cnt_q == TIMEOUT_C);
    assign drive   = (state == S_ISSUE) || (state == S_WAIT);

    // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = rm_res[2] ? S_RESP : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (sel_ack || expired) state_nxt = S_RESP;
            S_RESP:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        fflags_nxt = fflags_clr ? 5'b0 : fflags;
        if (state == S_WAIT && sel_ack)
            fflags_nxt = fflags_nxt | {~op_q & w_invalid, 3'b000, op_q ? f_inexact : w_inexact};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            op_q     <= 1'b0;
            uns_q    <= 1'b0;
            src_q    <= '0;
            tag_q    <= '0;
            rm_q     <= '0;
            res_q    <= '0;
            status_q <= ST_OK;
            cnt_q    <= '0;
            fflags   <= '0;
        end else begin
            fflags <= fflags_nxt;
            case (state)
                S_IDLE: if (in_valid) begin
                    op_q     <= in_op;
                    uns_q    <= in_unsigned;
                    src_q    <= in_src;
                    tag_q    <= in_tag;
                    rm_q     <= rm_res[1:0];
                    res_q    <= '0;
                    status_q <= rm_res[2] ? ST_ILLEGAL_RM : ST_OK;
                    cnt_q    <= '0;
                end
                S_ISSUE: cnt_q <= 8'd1;
                S_WAIT: begin
                    // An ack in the expiry cycle still counts as a successful conversion.
                    if (sel_ack) begin
                        res_q    <= op_q ? f_res : w_res;
                        status_q <= ST_OK;
                    end else if (expired) begin
                        res_q    <= '0;
                        status_q <= ST_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_RESP: if (out_ready) cnt_q <= '0;
                default: ;
            endcase
        end
    end

    assign in_ready   = (state == S_IDLE) && nrst;
    assign w_req      = (state == S_ISSUE) && !op_q;
    assign f_req      = (state == S_ISSUE) &&  op_q;
    assign w_src      = (drive && !op_q) ? src_q : '0;
    assign w_rm       = (drive && !op_q) ? rm_q  : '0;
    assign w_unsigned = drive && !op_q && uns_q;
    assign f_src      = (drive &&  op_q) ? src_q : '0;
    assign f_rm       = (drive &&  op_q) ? rm_q  : '0;
    assign f_unsigned = drive && op_q && uns_q;
    assign out_valid  = (state == S_RESP);
    assign out_res    = out_valid ? res_q : '0;
    assign out_status = out_valid ? status_q : ST_OK;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_ecliptic_converter_sequencer.sv
// Directed bench for ecliptic_converter_sequencer; expected responses are queued when
// commands are driven and compared when out_valid appears.
module tb_ecliptic_converter_sequencer;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
        logic [1:0]  status;
    } exp_t;

    logic        clk, nrst;
    logic        in_valid, in_ready, in_op, in_unsigned;
    logic [2:0]  in_rm, frm;
    logic [31:0] in_src;
    logic [4:0]  in_tag;
    logic        w_req, w_unsigned, w_ack, w_invalid, w_inexact;
    logic [31:0] w_src, w_res;
    logic [1:0]  w_rm;
    logic        f_req, f_unsigned, f_ack, f_inexact;
    logic [31:0] f_src, f_res;
    logic [1:0]  f_rm;
    logic        out_valid, out_ready, fflags_clr;
    logic [31:0] out_res;
    logic [4:0]  out_tag, fflags;
    logic [1:0]  out_status;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    ecliptic_converter_sequencer #(.TIMEOUT(15)) dut (
        .clk(clk), .nrst(nrst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_unsigned(in_unsigned),
        .in_rm(in_rm), .in_src(in_src), .in_tag(in_tag), .frm(frm),
        .w_req(w_req), .w_src(w_src), .w_rm(w_rm), .w_unsigned(w_unsigned),
        .w_ack(w_ack), .w_res(w_res), .w_invalid(w_invalid), .w_inexact(w_inexact),
        .f_req(f_req), .f_src(f_src), .f_rm(f_rm), .f_unsigned(f_unsigned),
        .f_ack(f_ack), .f_res(f_res), .f_inexact(f_inexact),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag),
        .out_status(out_status), .fflags(fflags), .fflags_clr(fflags_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic op, input logic uns, input logic [2:0] rm,
                         input logic [31:0] src, input logic [4:0] tag);
        in_op = op; in_unsigned = uns; in_rm = rm; in_src = src; in_tag = tag;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic compare_resp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_size"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_res"}, out_res, e.res);
            check({tag, "_tag"}, 32'(out_tag), 32'(e.tag));
            check({tag, "_status"}, 32'(out_status), 32'(e.status));
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int max_cycles);
        int n = 0;
        while (!out_valid && n < max_cycles) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (out_valid) begin
            compare_resp(tag);
            handshake();
        end
    endtask

    initial begin
        in_valid = 0; in_op = 0; in_unsigned = 0; in_rm = 0; in_src = 0; in_tag = 0; frm = 0;
        w_ack = 0; w_res = 0; w_invalid = 0; w_inexact = 0;
        f_ack = 0; f_res = 0; f_inexact = 0;
        out_ready = 0; fflags_clr = 0;
        nrst = 1'b1;
        #1 nrst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_reqs", {30'd0, w_req, f_req}, 32'd0);
        check("rst_out_res", out_res, 32'd0);
        check("rst_fflags", 32'(fflags), 32'd0);
        step(); step();
        nrst = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // float->word, RTZ, ack one cycle after req
        sb.push_back('{res: 32'd3, tag: 5'd3, status: 2'd0});
        issue(1'b0, 1'b0, 3'd1, 32'h4040_0000, 5'd3);
        check("t1_w_req", 32'(w_req), 32'd1);
        check("t1_f_req", 32'(f_req), 32'd0);
        check("t1_w_rm", 32'(w_rm), 32'd1);
        check("t1_w_src", w_src, 32'h4040_0000);
        check("t1_in_ready", 32'(in_ready), 32'd0);
        step();
        check("t1_w_req_once", 32'(w_req), 32'd0);
        check("t1_w_src_wait", w_src, 32'h4040_0000);
        w_ack = 1'b1; w_res = 32'd3;
        step();
        w_ack = 1'b0; w_res = 32'hFFFF_FFFF;
        check("t1_latency_valid", 32'(out_valid), 32'd1);
        check("t1_w_src_idle", w_src, 32'd0);
        check("t1_fflags", 32'(fflags), 32'd0);
        wait_resp("t1", 4);

        // word->float with DYN -> frm=2; stray w_ack must be ignored
        frm = 3'd2;
        sb.push_back('{res: 32'h40A0_0000, tag: 5'd9, status: 2'd0});
        issue(1'b1, 1'b0, 3'd7, 32'd5, 5'd9);
        check("t2_f_req", 32'(f_req), 32'd1);
        check("t2_w_req", 32'(w_req), 32'd0);
        check("t2_f_rm", 32'(f_rm), 32'd2);
        check("t2_f_src", f_src, 32'd5);
        step();
        w_ack = 1'b1; w_res = 32'hDEAD_BEEF; w_invalid = 1'b1;
        step();
        w_ack = 1'b0; w_invalid = 1'b0;
        check("t2_other_ack_ignored", 32'(out_valid), 32'd0);
        f_ack = 1'b1; f_res = 32'h40A0_0000; f_inexact = 1'b1;
        step();
        f_ack = 1'b0; f_inexact = 1'b0;
        check("t2_fflags", 32'(fflags), 32'h01);
        wait_resp("t2", 4);
        step();
        check("t2_fflags_sticky", 32'(fflags), 32'h01);
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        check("t2_fflags_clr", 32'(fflags), 32'd0);

        // illegal rounding modes: DYN->frm=4, and direct 5
        frm = 3'd4;
        sb.push_back('{res: 32'd0, tag: 5'd4, status: 2'd1});
        issue(1'b0, 1'b0, 3'd7, 32'h1234, 5'd4);
        check("t3a_no_req", {30'd0, w_req, f_req}, 32'd0);
        check("t3a_valid", 32'(out_valid), 32'd1);
        wait_resp("t3a", 1);
        sb.push_back('{res: 32'd0, tag: 5'd6, status: 2'd1});
        issue(1'b1, 1'b0, 3'd5, 32'h5678, 5'd6);
        check("t3b_no_req", {30'd0, w_req, f_req}, 32'd0);
        check("t3b_valid", 32'(out_valid), 32'd1);
        wait_resp("t3b", 1);
        check("t3_fflags", 32'(fflags), 32'd0);

        // backpressure in RESP with a pending command on the input
        frm = 3'd0;
        sb.push_back('{res: 32'h1234, tag: 5'd17, status: 2'd0});
        issue(1'b0, 1'b1, 3'd0, 32'd7, 5'd17);
        check("t4_w_unsigned", 32'(w_unsigned), 32'd1);
        step();
        w_ack = 1'b1; w_res = 32'h1234; w_invalid = 1'b1;
        step();
        w_ack = 1'b0; w_invalid = 1'b0;
        check("t4_fflags_nv", 32'(fflags), 32'h10);
        in_op = 1'b0; in_rm = 3'd5; in_src = 32'h99; in_tag = 5'd20; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_res", out_res, 32'h1234);
            check("t4_hold_tag", 32'(out_tag), 32'd17);
            check("t4_hold_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        compare_resp("t4");
        handshake();
        check("t4_released_valid", 32'(out_valid), 32'd0);
        check("t4_released_in_ready", 32'(in_ready), 32'd1);
        sb.push_back('{res: 32'd0, tag: 5'd20, status: 2'd1});
        step();
        in_valid = 1'b0;
        wait_resp("t4b", 1);

        // timeout exactly TIMEOUT cycles after entering WAIT
        sb.push_back('{res: 32'd0, tag: 5'd5, status: 2'd2});
        issue(1'b0, 1'b0, 3'd1, 32'h42, 5'd5);
        step();
        for (int i = 0; i < 14; i++) step();
        check("t5_not_yet", 32'(out_valid), 32'd0);
        step();
        check("t5_expired_valid", 32'(out_valid), 32'd1);
        wait_resp("t5", 1);
        check("t5_fflags", 32'(fflags), 32'h10);

        // ack on the expiry cycle wins
        sb.push_back('{res: 32'h55, tag: 5'd6, status: 2'd0});
        issue(1'b0, 1'b0, 3'd3, 32'h43, 5'd6);
        step();
        for (int i = 0; i < 14; i++) step();
        w_ack = 1'b1; w_res = 32'h55; w_inexact = 1'b1;
        step();
        w_ack = 1'b0; w_inexact = 1'b0;
        check("t6_valid", 32'(out_valid), 32'd1);
        wait_resp("t6", 1);
        check("t6_fflags", 32'(fflags), 32'h11);

        // reset during WAIT, ack right after release ignored
        issue(1'b1, 1'b0, 3'd0, 32'h77, 5'd11);
        step();
        nrst = 1'b0;
        #1;
        check("t7_rst_f_src", f_src, 32'd0);
        check("t7_rst_reqs", {30'd0, w_req, f_req}, 32'd0);
        check("t7_rst_in_ready", 32'(in_ready), 32'd0);
        check("t7_rst_fflags", 32'(fflags), 32'd0);
        check("t7_rst_tag", 32'(out_tag), 32'd0);
        sb.delete();
        step();
        nrst = 1'b1;
        f_ack = 1'b1; f_res = 32'hABCD;
        step();
        f_ack = 1'b0;
        check("t7_ack_ignored", 32'(out_valid), 32'd0);
        check("t7_idle_in_ready", 32'(in_ready), 32'd1);
        check("t7_out_res", out_res, 32'd0);
        sb.push_back('{res: 32'h4100_0000, tag: 5'd12, status: 2'd0});
        issue(1'b1, 1'b1, 3'd3, 32'd8, 5'd12);
        check("t7_f_rm", 32'(f_rm), 32'd3);
        check("t7_f_unsigned", 32'(f_unsigned), 32'd1);
        step();
        f_ack = 1'b1; f_res = 32'h4100_0000;
        step();
        f_ack = 1'b0;
        wait_resp("t7", 4);
        check("t7_fflags", 32'(fflags), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecliptic_converter_sequencer.md
ECLIPTIC_CONVERTER_SEQUENCER -- requirements
Module: ecliptic_converter_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, giving the max cycles spent in WAIT before abort (range 1..255).
REQ-002 SHALL have ports, clock and reset first: clk in 1, rising-edge clock; nrst in 1, asynchronous active-low reset.
REQ-003 SHALL have command ports: in_valid in 1; in_ready out 1; in_op in 1 (0=float->word, 1=word->float); in_unsigned in 1; in_rm in 3 (0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 7 DYN); in_src in 32; in_tag in 5 (destination register); frm in 3 (dynamic rounding mode).
REQ-004 SHALL have to-word converter ports: w_req out 1; w_src out 32; w_rm out 2; w_unsigned out 1; w_ack in 1; w_res in 32; w_invalid in 1; w_inexact in 1.
REQ-005 SHALL have to-float converter ports: f_req out 1; f_src out 32; f_rm out 2; f_unsigned out 1; f_ack in 1; f_res in 32; f_inexact in 1.
REQ-006 SHALL have response ports: out_valid out 1; out_ready in 1; out_res out 32; out_tag out 5; out_status out 2 (0 ok, 1 illegal rm, 2 timeout); fflags out 5 ({NV,DZ,OF,UF,NX}); fflags_clr in 1.

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; in_ready=1 only in IDLE.
REQ-008 IDLE: on in_valid, SHALL register op, unsigned, src, tag and resolved rm (in_rm, or frm when in_rm=7).
REQ-009 If resolved rm is 0..3, IDLE SHALL go to ISSUE; if 4, 5 or 6 (RMM unsupported by converters), IDLE SHALL go to RESP with out_status=1, out_res=0, and no converter request and no fflags update.
REQ-010 ISSUE SHALL assert exactly one of w_req (op=0) or f_req (op=1) for exactly one cycle, then enter WAIT; the other req SHALL stay 0.
REQ-011 w_src/f_src, w_rm/f_rm (= resolved rm[1:0]) and w_unsigned/f_unsigned SHALL be driven from the registered command for the whole ISSUE and WAIT period; they SHALL be 0 otherwise.
REQ-012 WAIT SHALL sample only the ack of the selected converter; an ack on the other converter SHALL be ignored.
REQ-013 On selected ack, SHALL capture w_res or f_res into out_res with out_status=0 and enter RESP; minimum command-accept-to-out_valid latency is 3 cycles (converter ack one cycle after req).
REQ-014 WAIT SHALL count cycles from 1; if TIMEOUT cycles elapse without ack, SHALL enter RESP with out_res=0, out_status=2 and no fflags update; an ack in the same cycle as expiry SHALL win (status 0).
REQ-015 RESP SHALL hold out_valid=1 and out_res/out_tag/out_status stable until out_ready=1, then go to IDLE; no new command is accepted in that same cycle.
REQ-016 On a status-0 capture, fflags SHALL OR in NV=w_invalid (op=0 only) and NX=w_inexact or f_inexact; DZ, OF, UF SHALL never be set by this block.
REQ-017 fflags SHALL be sticky; fflags_clr=1 SHALL zero them, and a capture in the same cycle SHALL apply after clear (captured bits survive).
REQ-018 out_tag SHALL equal the registered in_tag throughout RESP; out_res/out_status SHALL be 0 outside RESP.

Reset
REQ-019 While nrst=0, asynchronously: FSM=IDLE, in_ready=1 only after release (0 during reset), w_req=f_req=0, all converter drive outputs 0, out_valid=0, out_res=0, out_tag=0, out_status=0, fflags=0, timeout counter=0.
REQ-020 Reset asserted in any state SHALL abandon the command; a converter ack arriving in the first cycle after release SHALL be ignored (FSM in IDLE).

Verification
REQ-021 op=0, in_rm=1, in_src=0x40400000 (3.0), w_ack next cycle with w_res=3 -> w_req one cycle, w_rm=1, out_valid with out_res=3, out_status=0, fflags=0.
REQ-022 op=1, in_rm=7, frm=2, in_src=5, f_res=0x40A00000, f_inexact=1 -> f_rm=2, out_res=0x40A00000, fflags=0b00001 after capture, sticky until fflags_clr.
REQ-023 in_rm=7 with frm=4, and in_rm=5 -> no w_req/f_req, out_status=1 on cycle after accept, out_res=0, fflags unchanged.
REQ-024 out_ready held 0 for 10 cycles in RESP -> out_valid, out_res, out_tag constant; in_ready=0; in_valid ignored; accepted only after out_ready pulse.
REQ-025 TIMEOUT=15, no ack -> out_status=2 exactly 15 cycles after entering WAIT; ack on cycle 15 -> status 0 with captured result.
REQ-026 nrst pulsed low during WAIT, then ack arrives after release -> all outputs zero, ack ignored, next command processed normally.
